// File: rtl/ibuf_pkg.sv
// Shared types and helpers for the multi-issue instruction buffer.
// PC_WIDTH lives here because the stored entry struct is sized by it.
package ibuf_pkg;

  localparam int PC_WIDTH        = 48;
  localparam int FETCH_INSTS_DEF = 4;
  localparam int DEPTH_DEF       = 16;
  localparam int DEQ_WIDTH_DEF   = 2;

  typedef struct packed {
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] pc;
  } ibuf_entry_t;

  // Lane index of the first valid instruction within a fetch block.
  function automatic int start_lane(input logic [PC_WIDTH-1:0] pc, input int fetch_insts);
    logic [PC_WIDTH-1:0] word_idx;
    word_idx = pc >> 2;
    return int'(word_idx[15:0]) & (fetch_insts - 1);
  endfunction

  function automatic logic [PC_WIDTH-1:0] block_base(input logic [PC_WIDTH-1:0] pc,
                                                     input int fetch_insts);
    return pc & ~PC_WIDTH'(fetch_insts * 4 - 1);
  endfunction

endpackage

// File: rtl/ibuffer_multi_if.sv
// Fetch-side, backend-side and status signals of the instruction buffer.
// master = fetch path plus backend, slave = the buffer itself.
interface ibuffer_multi_if #(
  parameter int FETCH_INSTS = ibuf_pkg::FETCH_INSTS_DEF,
  parameter int DEPTH       = ibuf_pkg::DEPTH_DEF,
  parameter int DEQ_WIDTH   = ibuf_pkg::DEQ_WIDTH_DEF
);
  localparam int PCW = ibuf_pkg::PC_WIDTH;
  localparam int CW  = $clog2(DEPTH) + 1;

  logic                     flush_valid;
  logic                     fetch_valid;
  logic                     fetch_ready;
  logic [PCW-1:0]           fetch_pc;
  logic [32*FETCH_INSTS-1:0] fetch_data;
  logic [DEQ_WIDTH-1:0]     deq_valid;
  logic [32*DEQ_WIDTH-1:0]  deq_inst;
  logic [PCW*DEQ_WIDTH-1:0] deq_pc;
  logic                     deq_ready;
  logic [CW-1:0]            occupancy;
  logic                     empty;

  modport master (
    output flush_valid, fetch_valid, fetch_pc, fetch_data, deq_ready,
    input  fetch_ready, deq_valid, deq_inst, deq_pc, occupancy, empty
  );

  modport slave (
    input  flush_valid, fetch_valid, fetch_pc, fetch_data, deq_ready,
    output fetch_ready, deq_valid, deq_inst, deq_pc, occupancy, empty
  );

endinterface

// File: rtl/ibuf_lane_compact.sv
// Drops the lanes ahead of the start lane of a fetch block and packs the
// remaining instructions, each tagged with its own PC, down to slot 0.
module ibuf_lane_compact
  import ibuf_pkg::*;
#(
  parameter  int FETCH_INSTS = FETCH_INSTS_DEF,
  localparam int LW          = $clog2(FETCH_INSTS)
) (
  input  logic [32*FETCH_INSTS-1:0]        fetch_data,
  input  logic [PC_WIDTH-1:0]              fetch_pc,
  output ibuf_entry_t [FETCH_INSTS-1:0]    entries,
  output logic [LW:0]                      enq_n
);

  int                  s_lane;
  logic [PC_WIDTH-1:0] base_pc;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    s_lane  = start_lane(fetch_pc, FETCH_INSTS);
    base_pc = block_base(fetch_pc, FETCH_INSTS);
    enq_n   = (LW+1)'(FETCH_INSTS - s_lane);
    entries = '0;
    for (int j = 0; j < FETCH_INSTS; j++) begin
      if (s_lane + j < FETCH_INSTS) begin
        entries[j].inst = fetch_data[32*(s_lane+j) +: 32];
        entries[j].pc   = base_pc | PC_WIDTH'((s_lane + j) * 4);
      end
    end
  end

endmodule

// File: rtl/ibuffer_multi.sv
// Circular instruction buffer: whole-block enqueue, up to DEQ_WIDTH in-order
// instructions presented per cycle, single-cycle flush on redirect.
module ibuffer_multi
  import ibuf_pkg::*;
#(
  parameter int FETCH_INSTS = FETCH_INSTS_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int DEQ_WIDTH   = DEQ_WIDTH_DEF
) (
  input logic            clock,
  input logic            reset_n,
  ibuffer_multi_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(FETCH_INSTS);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  ibuf_entry_t   mem_q [DEPTH];
  ibuf_entry_t   mem_d [DEPTH];

  ibuf_entry_t [FETCH_INSTS-1:0] enq_entries;
  logic [LW:0]                   enq_n;
  logic                          enq_fire;
  logic [CW-1:0]                 deq_n;

  ibuf_lane_compact #(.FETCH_INSTS(FETCH_INSTS)) u_compact (
    .fetch_data (bus.fetch_data),
    .fetch_pc   (bus.fetch_pc),
    .entries    (enq_entries),
    .enq_n      (enq_n)
  );

  // Room is judged on the registered count alone, so a same-cycle dequeue
  // never lengthens the ready path.
  assign bus.fetch_ready = (count_q <= CW'(DEPTH - FETCH_INSTS)) && !bus.flush_valid;
  assign enq_fire        = bus.fetch_valid && bus.fetch_ready;

  always_comb begin
    deq_n = '0;
    if (bus.deq_ready) deq_n = (count_q < CW'(DEQ_WIDTH)) ? count_q : CW'(DEQ_WIDTH);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (bus.flush_valid) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(deq_n);
      count_d  = count_q - deq_n;
      if (enq_fire) begin
        for (int j = 0; j < FETCH_INSTS; j++) begin
          if ((LW+1)'(j) < enq_n) mem_d[wr_ptr_q + PW'(j)] = enq_entries[j];
        end
        wr_ptr_d = wr_ptr_q + PW'(enq_n);
        count_d  = count_d + CW'(enq_n);
      end
    end
  end

  // NOTE: state flops use non-blocking '<=' so every flop samples the values
  // from before the edge; blocking '=' stays in the combinational next-state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the data array is deliberately not reset; an entry is only ever
  // read while count says it holds live data.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    bus.deq_valid = '0;
    bus.deq_inst  = '0;
    bus.deq_pc    = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      bus.deq_valid[i]                    = count_q > CW'(i);
      bus.deq_inst[32*i +: 32]            = mem_q[rd_ptr_q + PW'(i)].inst;
      bus.deq_pc[PC_WIDTH*i +: PC_WIDTH]  = mem_q[rd_ptr_q + PW'(i)].pc;
    end
  end

  assign bus.occupancy = count_q;
  assign bus.empty     = (count_q == '0);

  a_fetch_pc_aligned: assert property (
    @(posedge clock) disable iff (!reset_n) bus.fetch_valid |-> bus.fetch_pc[1:0] == 2'b00);

endmodule

// File: doc/ibuffer_multi.md
Name: ibuffer_multi

Overview:
- Parametrised successor to the single-issue instruction buffer behind the IFU.
- Accepts one fetch block of FETCH_INSTS 32-bit instructions per cycle from the fetch path. The block may start mid-line after a redirect.
- Stores per-instruction {inst, pc} entries in a circular buffer of DEPTH entries.
- Presents up to DEQ_WIDTH in-order instructions per cycle to the backend. Supports a same-cycle flush on redirect.

Parameters:
- PC_WIDTH, 48, width of instruction addresses.
- FETCH_INSTS, 4, instructions per fetch block (128-bit fetch); power of two, >=2.
- DEPTH, 16, buffer entries; power of two, >= 2*FETCH_INSTS.
- DEQ_WIDTH, 2, instructions presented per cycle; 1 <= DEQ_WIDTH <= FETCH_INSTS.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush_valid  in  1  redirect; discards all buffered and incoming instructions.
- fetch_valid  in  1  fetch block present.
- fetch_ready  out  1  buffer can take a whole block.
- fetch_pc  in  PC_WIDTH  address of the first valid instruction in the block.
- fetch_data  in  32*FETCH_INSTS  lane i in bits [32i+31:32i].
- deq_valid  out  DEQ_WIDTH  per-lane valid; always a contiguous prefix starting at lane 0.
- deq_inst  out  32*DEQ_WIDTH  instruction per lane.
- deq_pc  out  PC_WIDTH*DEQ_WIDTH  PC per lane.
- deq_ready  in  1  backend takes every valid lane this cycle (driven by !backend_stall).
- occupancy  out  $clog2(DEPTH)+1  current entry count.
- empty  out  1  occupancy == 0.

Behaviour:
- Reset (async assert of reset_n) clears pointers and count. Outputs after reset: fetch_ready=1, deq_valid=0, occupancy=0, empty=1. deq_inst/deq_pc are don't-care while their lane is invalid.
- Reset asserted mid-operation drops all contents immediately; no partial state survives.
- Start lane: s = fetch_pc[$clog2(FETCH_INSTS)+1:2]. Only lanes s..FETCH_INSTS-1 are enqueued, so enq_n = FETCH_INSTS - s.
  - Enqueued entries are compacted: lane s goes to the write pointer.
  - Entry pc = {fetch_pc[PC_WIDTH-1:$clog2(FETCH_INSTS)+2], lane, 2'b00}.
- fetch_pc[1:0] != 0 is a protocol violation. Simulation assertion only; the RTL ignores those bits.
- fetch_ready = (occupancy <= DEPTH - FETCH_INSTS) && !flush_valid.
  - It is computed from the registered count only. It does not depend on same-cycle dequeue.
- Enqueue fires on fetch_valid && fetch_ready. Entries are visible at deq outputs the next cycle; latency is 1 cycle.
- Output lanes: deq_valid[i] = (occupancy > i). Lane i shows entry rd_ptr+i mod DEPTH.
- Dequeue fires on deq_ready. deq_n = number of valid lanes; rd_ptr and count retire deq_n.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - deq_n. Both pointers advance in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Entries spanning the wrap are read correctly.
- flush_valid has priority over everything:
  - Next cycle: count=0 and rd_ptr=wr_ptr.
  - Any fetch presented in the flush cycle is dropped.
  - Dequeue in the flush cycle is ignored.
  - deq_valid=0 the cycle after the flush.
- No overflow is possible under this handshake. An underflow condition does not exist because deq_n is derived from count.
- Storage is flops, with no reset on the data array. Only pointers and count are reset.

Decomposition:
- Package ibuf_pkg:
  - ibuf_entry_t struct {logic [31:0] inst; logic [PC_WIDTH-1:0] pc;}.
  - Default parameter constants.
  - Helper functions for start-lane extraction and the block-base PC.
- One sub-module: ibuf_lane_compact (combinational).
  - Takes fetch_data and fetch_pc.
  - Produces FETCH_INSTS compacted ibuf_entry_t plus enq_n.
- The parent holds the array, pointers, count, flush and output muxing.

Test Plan:
- Reset: hold reset_n=0 with fetch_valid=1 -> fetch_ready=1, deq_valid=2'b00, occupancy=0, empty=1; nothing is enqueued.
- Aligned block: fetch_pc=0x80000000, lanes 0x00000013, 0x00100093, 0x00200113, 0x00300193, deq_ready=1.
  - Next cycle: deq_valid=2'b11, inst 0x00000013/0x00100093, pc 0x80000000/0x80000004, occupancy=4.
  - Following cycle: pc 0x80000008/0x8000000C, occupancy=2.
  - Then occupancy=0.
- Unaligned redirect block: fetch_pc=0x80000008 -> occupancy=2, deq pc 0x80000008/0x8000000C, inst = lanes 2 and 3. A single remaining entry shows deq_valid=2'b01.
- Full/backpressure: deq_ready=0, four aligned blocks.
  - fetch_ready stays 1 through occupancy 12.
  - fetch_ready is 0 at occupancy 16.
  - One dequeue gives 14, fetch_ready still 0. A second gives 12, fetch_ready=1.
- Flush collision: occupancy=6, then assert flush_valid together with fetch_valid=1 and deq_ready=1.
  - fetch_ready=0 that cycle.
  - Next cycle: occupancy=0, deq_valid=0; the fetched block is absent.
- Wrap-around: 20 consecutive aligned blocks from 0x80000000 with deq_ready toggling 1,1,0.
  - Dequeued PCs strictly increment by 4 across pointer wrap with no loss or duplication.
  - occupancy never exceeds 16.
